// File: rtl/elevator_if.sv
// Request and status bundle between the elevator core and its surroundings.
interface elevator_if #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
);
  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic [FLOOR_W-1:0]    floor;
  logic                  dir;
  logic                  moving;
  logic                  door_open;
  logic                  arrive;
  logic [NUM_FLOORS-1:0] pending;
  logic [3:0]            motor;

  modport master (
    output req_valid, req_floor,
    input  floor, dir, moving, door_open, arrive, pending, motor
  );

  modport slave (
    input  req_valid, req_floor,
    output floor, dir, moving, door_open, arrive, pending, motor
  );
endinterface

// File: rtl/elevator_core.sv
// SCAN-order elevator controller: request bitmap, travel/dwell timing, stepper drive.
module elevator_core #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic      CLK,
  input  logic      RST_N,
  elevator_if.slave bus
);
  localparam int unsigned TRAV_W  = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DWELL_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t                r_state, w_state_n;
  logic [FLOOR_W-1:0]    r_floor, w_floor_n, w_next_floor;
  logic                  r_dir, w_dir_n;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_n;
  logic [NUM_FLOORS-1:0] w_set, w_clr, w_cur_oh, w_nxt_oh;
  logic [3:0]            r_motor, w_motor_n;
  logic                  r_arrive, w_arrive_n;
  logic                  r_moving, r_door_open;
  logic [TRAV_W-1:0]     r_trav_cnt, w_trav_n;
  logic [DWELL_W-1:0]    r_dwell_cnt, w_dwell_n;
  logic                  w_up, w_down, w_ahead, w_behind;

  // Decode incoming request, current/next floor and where outstanding work lies.
  always_comb begin
    w_next_floor = r_dir ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
    w_set    = '0;
    w_cur_oh = '0;
    w_nxt_oh = '0;
    w_up     = 1'b0;
    w_down   = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      w_set[i]    = bus.req_valid && (bus.req_floor == FLOOR_W'(i));
      w_cur_oh[i] = (r_floor == FLOOR_W'(i));
      w_nxt_oh[i] = (w_next_floor == FLOOR_W'(i));
      if (r_pending[i] && (FLOOR_W'(i) > r_floor)) w_up = 1'b1;
      if (r_pending[i] && (FLOOR_W'(i) < r_floor)) w_down = 1'b1;
    end
    w_ahead  = r_dir ? w_up : w_down;
    w_behind = r_dir ? w_down : w_up;
  end

  // Next-state, datapath and output decisions.
  always_comb begin
    w_state_n  = r_state;
    w_floor_n  = r_floor;
    w_dir_n    = r_dir;
    w_motor_n  = 4'b0000;
    w_arrive_n = 1'b0;
    w_trav_n   = '0;
    w_dwell_n  = '0;
    w_clr      = '0;
    case (r_state)
      S_IDLE: begin
        if (|((r_pending | w_set) & w_cur_oh)) begin
          w_state_n = S_DOOR;
          w_clr     = w_cur_oh;
        end else if (w_ahead) begin
          w_state_n = S_MOVE;
          w_motor_n = 4'b0001;
        end else if (w_behind) begin
          w_state_n = S_MOVE;
          w_dir_n   = ~r_dir;
          w_motor_n = 4'b0001;
        end
      end
      S_MOVE: begin
        w_motor_n = r_dir ? {r_motor[2:0], r_motor[3]} : {r_motor[0], r_motor[3:1]};
        w_trav_n  = r_trav_cnt + TRAV_W'(1);
        if (r_trav_cnt == TRAV_W'(TRAVEL_CYCLES - 1)) begin
          w_floor_n = w_next_floor;
          w_trav_n  = '0;
          if (|((r_pending | w_set) & w_nxt_oh)) begin
            w_state_n  = S_DOOR;
            w_clr      = w_nxt_oh;
            w_arrive_n = 1'b1;
            w_motor_n  = 4'b0000;
          end
        end
      end
      S_DOOR: begin
        // Requests for the open floor are absorbed and hold the door.
        w_clr = w_cur_oh;
        if (|(w_set & w_cur_oh)) begin
          w_dwell_n = '0;
        end else if (r_dwell_cnt == DWELL_W'(DOOR_CYCLES - 1)) begin
          w_state_n = S_IDLE;
        end else begin
          w_dwell_n = r_dwell_cnt + DWELL_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_pending_n = (r_pending | w_set) & ~w_clr;
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_floor     <= '0;
      r_dir       <= 1'b1;
      r_pending   <= '0;
      r_motor     <= 4'b0000;
      r_arrive    <= 1'b0;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_trav_cnt  <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_floor     <= w_floor_n;
      r_dir       <= w_dir_n;
      r_pending   <= w_pending_n;
      r_motor     <= w_motor_n;
      r_arrive    <= w_arrive_n;
      r_moving    <= (w_state_n == S_MOVE);
      r_door_open <= (w_state_n == S_DOOR);
      r_trav_cnt  <= w_trav_n;
      r_dwell_cnt <= w_dwell_n;
    end
  end

  assign bus.floor     = r_floor;
  assign bus.dir       = r_dir;
  assign bus.moving    = r_moving;
  assign bus.door_open = r_door_open;
  assign bus.arrive    = r_arrive;
  assign bus.pending   = r_pending;
  assign bus.motor     = r_motor;

  // A floor step never leaves the shaft.
  a_floor_bounds: assert property (@(posedge CLK) disable iff (!RST_N)
    (r_state == S_MOVE && r_trav_cnt == TRAV_W'(TRAVEL_CYCLES - 1)) |->
      (r_dir ? (32'(r_floor) < NUM_FLOORS - 1) : (r_floor != '0)));
endmodule

// File: tb/tb_elevator_core.sv
// Bench for elevator_core: directed trips with a stop scoreboard checked on door openings.
module tb_elevator_core;
  localparam int unsigned NF   = 8;
  localparam int unsigned FW   = 3;
  localparam int unsigned NF_B = 6;
  localparam int unsigned FW_B = 3;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  elevator_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus_a ();
  elevator_if #(.NUM_FLOORS(NF_B), .FLOOR_W(FW_B)) bus_b ();

  elevator_core #(.NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_a.slave)
  );
  elevator_core #(.NUM_FLOORS(NF_B), .FLOOR_W(FW_B), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_b.slave)
  );

  typedef struct {
    logic [2:0] floor;
    logic       dir;
    logic       arrive;
    logic [7:0] pending;
  } stop_t;

  stop_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  door_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req_a(input logic [2:0] f);
    bus_a.req_valid = 1'b1;
    bus_a.req_floor = f;
    tick();
    bus_a.req_valid = 1'b0;
  endtask

  task automatic req_b(input logic [2:0] f);
    bus_b.req_valid = 1'b1;
    bus_b.req_floor = f;
    tick();
    bus_b.req_valid = 1'b0;
  endtask

  task automatic expect_stop(input logic [2:0] f, input logic d, input logic a, input logic [7:0] p);
    stop_t s;
    s.floor = f; s.dir = d; s.arrive = a; s.pending = p;
    sb.push_back(s);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (!(!bus_a.moving && !bus_a.door_open && bus_a.pending == '0) && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 32'(!bus_a.moving && !bus_a.door_open && bus_a.pending == '0), 32'd1);
  endtask

  // Monitor: every door opening must match the next expected stop.
  always @(negedge CLK) begin
    if (!RST_N) begin
      door_prev = 1'b0;
    end else begin
      if (bus_a.door_open && !door_prev) begin
        if (sb.size() == 0) begin
          chk("stop_unexpected", 32'(bus_a.floor), 32'hFFFF);
        end else begin
          stop_t s;
          s = sb.pop_front();
          chk("stop_floor", 32'(bus_a.floor), 32'(s.floor));
          chk("stop_dir", 32'(bus_a.dir), 32'(s.dir));
          chk("stop_arrive", 32'(bus_a.arrive), 32'(s.arrive));
          chk("stop_pending", 32'(bus_a.pending), 32'(s.pending));
        end
      end
      door_prev = bus_a.door_open;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ef;
    RST_N = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_floor = '0;
    bus_b.req_valid = 1'b0; bus_b.req_floor = '0;

    // Asynchronous reset before any clock edge.
    #1 RST_N = 1'b0;
    #1;
    chk("rst_floor", 32'(bus_a.floor), 32'd0);
    chk("rst_dir", 32'(bus_a.dir), 32'd1);
    chk("rst_pending", 32'(bus_a.pending), 32'd0);
    chk("rst_motor", 32'(bus_a.motor), 32'd0);
    chk("rst_door", 32'(bus_a.door_open), 32'd0);
    chk("rst_arrive", 32'(bus_a.arrive), 32'd0);
    chk("rst_moving", 32'(bus_a.moving), 32'd0);
    @(negedge CLK) RST_N = 1'b1;
    tick(); tick();

    // Single trip 0 -> 3 with per-cycle timing and motor sequence.
    expect_stop(3'd3, 1'b1, 1'b1, 8'h00);
    req_a(3'd3);
    chk("trip_pending_t", 32'(bus_a.pending), 32'h08);
    chk("trip_idle_t", 32'(bus_a.moving), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      ef = ((k - 1) / 4 > 3) ? 3 : (k - 1) / 4;
      chk("trip_floor", 32'(bus_a.floor), 32'(ef));
      chk("trip_moving", 32'(bus_a.moving), 32'(k <= 12));
      chk("trip_motor", 32'(bus_a.motor), (k <= 12) ? (32'd1 << ((k - 1) % 4)) : 32'd0);
      chk("trip_door", 32'(bus_a.door_open), 32'(k >= 13 && k <= 15));
      chk("trip_arrive", 32'(bus_a.arrive), 32'(k == 13));
    end
    chk("trip_pending_end", 32'(bus_a.pending), 32'd0);

    // SCAN order: heading 3 -> 6, requests for 5 and 1 arrive on the way.
    expect_stop(3'd5, 1'b1, 1'b1, 8'h42);
    expect_stop(3'd6, 1'b1, 1'b1, 8'h02);
    expect_stop(3'd1, 1'b0, 1'b1, 8'h00);
    req_a(3'd6);
    tick();
    req_a(3'd5);
    req_a(3'd1);
    wait_idle("scan_done", 200);
    chk("scan_floor", 32'(bus_a.floor), 32'd1);
    chk("scan_dir", 32'(bus_a.dir), 32'd0);

    // Move to floor 2, then request the current floor and extend the dwell.
    expect_stop(3'd2, 1'b1, 1'b1, 8'h00);
    req_a(3'd2);
    wait_idle("to2_done", 100);
    expect_stop(3'd2, 1'b1, 1'b0, 8'h00);
    req_a(3'd2);
    chk("cur_door", 32'(bus_a.door_open), 32'd1);
    chk("cur_floor", 32'(bus_a.floor), 32'd2);
    chk("cur_motor", 32'(bus_a.motor), 32'd0);
    chk("cur_arrive", 32'(bus_a.arrive), 32'd0);
    tick();
    chk("cur_door_c2", 32'(bus_a.door_open), 32'd1);
    req_a(3'd2);
    chk("absorb_pending", 32'(bus_a.pending), 32'd0);
    chk("absorb_door0", 32'(bus_a.door_open), 32'd1);
    tick();
    chk("absorb_door1", 32'(bus_a.door_open), 32'd1);
    tick();
    chk("absorb_door2", 32'(bus_a.door_open), 32'd1);
    tick();
    chk("absorb_door_off", 32'(bus_a.door_open), 32'd0);
    chk("absorb_moving", 32'(bus_a.moving), 32'd0);

    // Out-of-range requests on a six-floor car.
    req_b(3'd7);
    req_b(3'd6);
    tick(); tick();
    chk("oor_pending", 32'(bus_b.pending), 32'd0);
    chk("oor_moving", 32'(bus_b.moving), 32'd0);
    chk("oor_door", 32'(bus_b.door_open), 32'd0);
    req_b(3'd5);
    chk("inrange_pending", 32'(bus_b.pending), 32'h20);

    // Request for floor 4 on the very edge the car reaches it.
    expect_stop(3'd4, 1'b1, 1'b1, 8'h40);
    req_a(3'd6);
    repeat (8) tick();
    chk("edge_floor_pre", 32'(bus_a.floor), 32'd3);
    req_a(3'd4);
    chk("edge_floor", 32'(bus_a.floor), 32'd4);
    chk("edge_arrive", 32'(bus_a.arrive), 32'd1);
    chk("edge_pending", 32'(bus_a.pending), 32'h40);

    // Reset in the middle of the next leg.
    begin
      int n;
      n = 0;
      while (!bus_a.moving && n < 20) begin
        tick();
        n++;
      end
      chk("leg_moving", 32'(bus_a.moving), 32'd1);
    end
    tick(); tick();
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_floor", 32'(bus_a.floor), 32'd0);
    chk("mid_rst_dir", 32'(bus_a.dir), 32'd1);
    chk("mid_rst_pending", 32'(bus_a.pending), 32'd0);
    chk("mid_rst_motor", 32'(bus_a.motor), 32'd0);
    chk("mid_rst_moving", 32'(bus_a.moving), 32'd0);
    chk("mid_rst_door", 32'(bus_a.door_open), 32'd0);
    chk("mid_rst_arrive", 32'(bus_a.arrive), 32'd0);
    chk("mid_rst_pending_b", 32'(bus_b.pending), 32'd0);
    tick(); tick();
    @(negedge CLK) RST_N = 1'b1;
    repeat (10) tick();
    chk("post_rst_floor", 32'(bus_a.floor), 32'd0);
    chk("post_rst_moving", 32'(bus_a.moving), 32'd0);
    chk("post_rst_motor", 32'(bus_a.motor), 32'd0);
    chk("post_rst_pending", 32'(bus_a.pending), 32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
